// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// master drives the fetch side and the downstream ready; slave is the decode stage.
interface decode_stage_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic [AWIDTH-1:0] pc_i;
  logic [DWIDTH-1:0] insn_i;
  logic              valid_i;
  logic              ready_o;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;
  logic [6:0]        opcode_o;
  logic [4:0]        rd_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic [2:0]        funct3_o;
  logic [6:0]        funct7_o;
  logic [31:0]       imm_o;
  logic              illegal_o;

  modport master (
    output pc_i, insn_i, valid_i, flush_i, ready_i,
    input  ready_o, valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, imm_o, illegal_o
  );

  modport slave (
    input  pc_i, insn_i, valid_i, flush_i, ready_i,
    output ready_o, valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, imm_o, illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: 2-entry head+skid buffer, decode done at enqueue,
// registered ready so downstream ready never reaches upstream ready combinationally.
module decode_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              illegal;
  } entry_t;

  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  entry_t     dec;
  logic [1:0] cnt_q, cnt_d;
  logic       rdy_q, rdy_d;
  logic       acc, ret;
  logic [31:0] w;

  // Decode the presented instruction so it is stored already decoded.
  always_comb begin
    w           = bus.insn_i[31:0];
    dec         = '0;
    dec.pc      = bus.pc_i;
    dec.insn    = bus.insn_i;
    dec.opcode  = w[6:0];
    dec.rd      = w[11:7];
    dec.funct3  = w[14:12];
    dec.rs1     = w[19:15];
    dec.rs2     = w[24:20];
    dec.funct7  = w[31:25];
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: dec.imm = {{20{w[31]}}, w[31:20]};
      7'h23:                      dec.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63:                      dec.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'h37, 7'h17:               dec.imm = {w[31:12], 12'b0};
      7'h6F:                      dec.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:                    dec.imm = 32'h0;
    endcase
    dec.illegal = (w[1:0] != 2'b11) ||
                  !(w[6:0] inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                   7'h37, 7'h63, 7'h67, 7'h6F, 7'h73});
  end

  assign acc = bus.valid_i && rdy_q;
  assign ret = (cnt_q != 2'd0) && bus.ready_i;

  // Buffer update: flush wins, then accept/retire with in-order promotion.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (bus.flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({acc, ret})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = dec;
          else               skid_d = dec;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = skid_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // acc implies cnt_q < 2, so the new entry becomes head when alone
          if (cnt_q == 2'd1) begin
            head_d = dec;
          end else begin
            head_d = skid_q;
            skid_d = dec;
          end
        end
        default: ;
      endcase
    end
    rdy_d = (cnt_d != 2'd2);
  end

  // State registers; reset clears everything, including the visible head data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bus.ready_o   = rdy_q;
  assign bus.valid_o   = (cnt_q != 2'd0);
  assign bus.pc_o      = head_q.pc;
  assign bus.insn_o    = head_q.insn;
  assign bus.opcode_o  = head_q.opcode;
  assign bus.rd_o      = head_q.rd;
  assign bus.rs1_o     = head_q.rs1;
  assign bus.rs2_o     = head_q.rs2;
  assign bus.funct3_o  = head_q.funct3;
  assign bus.funct7_o  = head_q.funct7;
  assign bus.imm_o     = head_q.imm;
  assign bus.illegal_o = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps plus a random stream,
// all checked against a queue-based reference of held entries.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  ent_t q[$];
  bit   mready = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Immediate per the format rules, built with integer arithmetic.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int v;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: v = $signed(w) >>> 20;
      7'h23: v = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
      7'h63: begin
        v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) v = v - 4096;
      end
      7'h37, 7'h17: v = int'(w & 32'hFFFFF000);
      7'h6F: begin
        v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (w[31]) v = v - (1 << 20);
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic bit ref_illegal(input logic [31:0] w);
    logic [6:0] legal [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                               7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    bit found = 1'b0;
    foreach (legal[k]) if (legal[k] == w[6:0]) found = 1'b1;
    return (w[1:0] != 2'b11) || !found;
  endfunction

  task automatic check_out();
    ent_t h;
    chk("valid_o", bus.valid_o, q.size() != 0);
    chk("ready_o", bus.ready_o, mready);
    if (q.size() != 0) begin
      h = q[0];
      chk("pc_o",      bus.pc_o,      h.pc);
      chk("insn_o",    bus.insn_o,    h.insn);
      chk("opcode_o",  bus.opcode_o,  h.insn[6:0]);
      chk("rd_o",      bus.rd_o,      h.insn[11:7]);
      chk("funct3_o",  bus.funct3_o,  h.insn[14:12]);
      chk("rs1_o",     bus.rs1_o,     h.insn[19:15]);
      chk("rs2_o",     bus.rs2_o,     h.insn[24:20]);
      chk("funct7_o",  bus.funct7_o,  h.insn[31:25]);
      chk("imm_o",     bus.imm_o,     ref_imm(h.insn));
      chk("illegal_o", bus.illegal_o, ref_illegal(h.insn));
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] insn,
                       input bit rdy, input bit fl);
    bus.valid_i = v;
    bus.pc_i    = pc;
    bus.insn_i  = insn;
    bus.ready_i = rdy;
    bus.flush_i = fl;
  endtask

  // One clock: predict from pre-edge inputs, then check just after the edge.
  task automatic cyc();
    bit   acc, ret, fl;
    ent_t e;
    acc    = bus.valid_i && mready;
    ret    = (q.size() != 0) && bus.ready_i;
    fl     = bus.flush_i;
    e.pc   = bus.pc_i;
    e.insn = bus.insn_i;
    @(posedge clk);
    #1;
    if (!rst) begin
      q.delete();
      mready = 1'b0;
    end else begin
      if (fl) q.delete();
      else begin
        if (ret) q.delete(0);
        if (acc) q.push_back(e);
      end
      mready = (q.size() < 2);
    end
    check_out();
  endtask

  logic [6:0] opc_pool [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                                7'h63, 7'h67, 7'h6F, 7'h73, 7'h0B, 7'h7F};

  initial begin
    logic [31:0] w;
    int idx;
    bit v;
    drive(0, 32'h0, 32'h0, 0, 0);

    // reset state
    #1;
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_ready", bus.ready_o, 1'b0);
    chk("rst_pc",    bus.pc_o,    32'h0);
    chk("rst_imm",   bus.imm_o,   32'h0);
    cyc();
    @(negedge clk) rst = 1'b1;
    cyc();

    // addi x1,x0,5
    drive(1, 32'h01000000, 32'h00500093, 1, 0);
    cyc();
    chk("addi_valid",   bus.valid_o,   1'b1);
    chk("addi_opcode",  bus.opcode_o,  7'h13);
    chk("addi_rd",      bus.rd_o,      5'd1);
    chk("addi_rs1",     bus.rs1_o,     5'd0);
    chk("addi_imm",     bus.imm_o,     32'h00000005);
    chk("addi_illegal", bus.illegal_o, 1'b0);

    // beq then lui, back to back
    drive(1, 32'h01000004, 32'hFE000EE3, 1, 0);
    cyc();
    chk("beq_imm", bus.imm_o, 32'hFFFFFFFC);
    drive(1, 32'h01000008, 32'h123452B7, 1, 0);
    cyc();
    chk("lui_rd",  bus.rd_o,  5'd5);
    chk("lui_imm", bus.imm_o, 32'h12345000);
    drive(0, 32'h0, 32'h0, 1, 0);
    cyc();

    // stream with downstream stalled for 3 cycles
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      v = (idx < 8);
      drive(v, 32'h01000000 + 32'(4 * idx), 32'h00000013 | 32'(idx << 7), c >= 3, 0);
      if (v && mready) idx++;
      cyc();
      if (c >= 1 && c <= 2) chk("stall_pc", bus.pc_o, 32'h01000000);
    end
    chk("stream_all_accepted", idx, 8);
    chk("stream_drained", q.size(), 0);

    // flush with 2 held and a valid instruction presented
    drive(1, 32'h00002000, 32'h00000013, 0, 0); cyc();
    drive(1, 32'h00002004, 32'h00000093, 0, 0); cyc();
    drive(1, 32'h00002008, 32'h00100113, 0, 1); cyc();
    chk("flush_valid", bus.valid_o, 1'b0);
    chk("flush_ready", bus.ready_o, 1'b1);
    drive(0, 32'h0, 32'h0, 1, 0); cyc(); cyc();
    // flush with 1 held while an accept would otherwise happen
    drive(1, 32'h00002100, 32'h00000013, 0, 0); cyc();
    drive(1, 32'h00002104, 32'h00000093, 1, 1); cyc();
    drive(0, 32'h0, 32'h0, 1, 0); cyc();

    // all-zero instruction is illegal but flows through
    drive(1, 32'h00004000, 32'h00000000, 1, 0); cyc();
    chk("zero_illegal", bus.illegal_o, 1'b1);
    chk("zero_imm",     bus.imm_o,     32'h0);
    drive(0, 32'h0, 32'h0, 1, 0); cyc();
    chk("zero_retired", bus.valid_o, 1'b0);

    // random stream
    for (int c = 0; c < 400; c++) begin
      w = $urandom();
      w[6:0] = opc_pool[$urandom_range(0, 12)];
      if ($urandom_range(0, 9) == 0) w[1:0] = 2'($urandom_range(0, 2));
      drive($urandom_range(0, 3) != 0, $urandom(), w,
            $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
      cyc();
    end

    // asynchronous reset mid-stream
    drive(1, 32'h00005000, 32'h00000013, 0, 0); cyc();
    drive(1, 32'h00005004, 32'h00000093, 0, 0); cyc();
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", bus.valid_o, 1'b0);
    chk("arst_ready", bus.ready_o, 1'b0);
    chk("arst_pc",    bus.pc_o,    32'h0);
    q.delete();
    mready = 1'b0;
    drive(1, 32'h00005008, 32'h00000113, 1, 0); cyc();
    @(negedge clk) rst = 1'b1;
    drive(1, 32'h00006000, 32'h00A00193, 1, 0); cyc();
    chk("post_rst_ready", bus.ready_o, 1'b1);
    cyc();
    chk("post_rst_pc", bus.pc_o, 32'h00006000);
    drive(0, 32'h0, 32'h0, 1, 0); cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, instruction width.
REQ-002 SHALL have parameter AWIDTH, default 32, PC width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports pc_i (input, AWIDTH) and insn_i (input, DWIDTH), fetched PC and instruction from fetch.
REQ-006 SHALL have ports valid_i (input, 1) and ready_o (output, 1), the upstream handshake.
REQ-007 SHALL have port flush_i, input, 1, synchronous discard of all held and presented instructions.
REQ-008 SHALL have ports valid_o (output, 1) and ready_i (input, 1), the downstream handshake.
REQ-009 SHALL have outputs pc_o (AWIDTH), insn_o (DWIDTH), opcode_o (7), rd_o (5), rs1_o (5), rs2_o (5), funct3_o (3), funct7_o (7), imm_o (32) and illegal_o (1), all registered decode results.

Function
REQ-010 SHALL hold a 2-entry in-order buffer (head + skid), with decode performed at enqueue and stored per entry.
REQ-011 SHALL accept an entry when valid_i && ready_o at a clock edge, and retire the head when valid_o && ready_i.
REQ-012 SHALL drive ready_o from a register: 1 iff fewer than 2 entries are held; no combinational path from ready_i to ready_o.
REQ-013 SHALL assert valid_o iff at least 1 entry is held; outputs SHALL show the head entry.
REQ-014 SHALL give 1-cycle latency: an instruction accepted into an empty buffer appears on valid_o the next cycle.
REQ-015 SHALL, on simultaneous accept and retire, keep the count unchanged, with the skid (if held) promoted to head and the new entry behind it.
REQ-016 SHALL hold the head's outputs stable while valid_o && !ready_i.
REQ-017 SHALL, on flush_i=1, empty both entries at that edge, ignore any accept or retire in that cycle, and give valid_o=0 and ready_o=1 next cycle; flush_i has priority.
REQ-018 SHALL extract opcode=insn[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20] and funct7=[31:25] for every format.
REQ-019 SHALL sign-extend imm_o to 32 bits by format:
- I (0x03/0x13/0x67/0x73): insn[31:20]
- S (0x23): {[31:25],[11:7]}
- B (0x63): {[31],[7],[30:25],[11:8],0}
- U (0x37/0x17): {[31:12],12'b0}
- J (0x6F): {[31],[19:12],[20],[30:21],0}
- all others: 0
REQ-020 SHALL set illegal_o=1 when insn[1:0]!=2'b11 or opcode is outside {0x03,0x0F,0x13,0x17,0x23,0x33,0x37,0x63,0x67,0x6F,0x73}; the entry still flows normally.
REQ-021 SHALL never drop, duplicate or reorder entries outside flush.

Reset
REQ-022 SHALL, while rst=0, immediately empty the buffer and force valid_o=0, ready_o=0 and all data outputs to 0.
REQ-023 SHALL drive ready_o=1 from the first clock edge after rst deasserts; reset mid-stream discards all held entries.

Verification
REQ-024 Check that pc_i=0x01000000, insn_i=0x00500093 into an empty buffer gives, next cycle, valid_o=1, opcode 0x13, rd 1, rs1 0, imm_o 0x00000005, illegal_o 0.
REQ-025 Check that insn 0xFE000EE3 (beq x0,x0,-4) gives imm_o=0xFFFFFFFC, and insn 0x123452B7 (lui x5) gives rd 5, imm_o=0x12345000.
REQ-026 Check that a back-to-back stream of PCs 0x01000000, +4, +8… with ready_i=0 for 3 cycles gives: ready_o drops after 2 accepts, all PCs emerge in order with none lost, and head outputs are stable while stalled.
REQ-027 Check that flush_i=1 with 2 entries held and valid_i=1 gives valid_o=0 and ready_o=1 next cycle, and the presented instruction never appears.
REQ-028 Check that insn 0x00000000 gives illegal_o=1, imm_o=0, and the entry handshakes out normally.
REQ-029 Check that rst=0 asserted mid-stream between clock edges forces valid_o=0 at once, and after release the first accepted instruction is the first output.
